// File: rtl/fp_adder_host.sv
// fp_adder_host: parallel valid/ready host for the serial FP adder; takes op_a..op_d/sub_op/lane_en on start_*, drives setup/operand frames on setup_serial_out/serial1..4_out/wr_out, reads the result via output_read_out/dut_serial_in into result_out on result_*; FP_ADDER_HOST_TIMEOUT_EN adds a WAIT_RDY timeout reported on timeout_err
module fp_adder_host #(
  parameter int WIDTH = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_valid_in,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a_in,
  input  logic [WIDTH-1:0] op_b_in,
  input  logic [WIDTH-1:0] op_c_in,
  input  logic [WIDTH-1:0] op_d_in,
  input  logic [2:0]       sub_op_in,
  input  logic [3:0]       lane_en_in,
  output logic             result_valid,
  input  logic             result_ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             timeout_err,
  input  logic             dut_input_rdy_in,
  input  logic             dut_output_rdy_in,
  input  logic             dut_serial_in,
  output logic             serial1_out,
  output logic             serial2_out,
  output logic             serial3_out,
  output logic             serial4_out,
  output logic             setup_serial_out,
  output logic             wr_out,
  output logic             output_read_out,
  output logic             output_clk_out
);
  typedef enum logic [2:0] {IDLE, SETUP, GAP, LOAD, WAIT_RDY, READ, DONE} state_t;
  state_t state, ns;
  logic [4:0] cnt, cnt_n;
  logic [7:0] sw, sw_n;
  logic [WIDTH-1:0] op_a, op_b, op_c, op_d, a_n, b_n, c_n, d_n, res_n;
  logic acc, to_hit;
  assign start_ready = state == IDLE && dut_input_rdy_in;
  assign acc = start_valid_in && start_ready;
  assign output_clk_out = 1'b0;
  always_comb begin
    ns = state == IDLE ? (acc ? SETUP : IDLE)
       : state == SETUP ? (cnt == 5'd7 ? GAP : SETUP)
       : state == GAP ? LOAD
       : state == LOAD ? (cnt == 5'd15 ? WAIT_RDY : LOAD)
       : state == WAIT_RDY ? (dut_output_rdy_in ? READ : to_hit ? DONE : WAIT_RDY)
       : state == READ ? (cnt == 5'd15 ? DONE : READ)
       : result_ready_in ? IDLE : DONE;
    cnt_n = ns != state ? 5'd0 : cnt + 5'd1;
    sw_n = acc ? {sub_op_in, lane_en_in, 1'b0} : sw;
    a_n = acc ? op_a_in : op_a;
    b_n = acc ? op_b_in : op_b;
    c_n = acc ? op_c_in : op_c;
    d_n = acc ? op_d_in : op_d;
    res_n = state == READ ? {result_out[WIDTH-2:0], dut_serial_in} : to_hit ? '0 : result_out;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      sw <= '0;
      op_a <= '0;
      op_b <= '0;
      op_c <= '0;
      op_d <= '0;
      result_out <= '0;
      wr_out <= 1'b0;
      setup_serial_out <= 1'b0;
      serial1_out <= 1'b0;
      serial2_out <= 1'b0;
      serial3_out <= 1'b0;
      serial4_out <= 1'b0;
      output_read_out <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state <= ns;
      cnt <= cnt_n;
      sw <= sw_n;
      op_a <= a_n;
      op_b <= b_n;
      op_c <= c_n;
      op_d <= d_n;
      result_out <= res_n;
      wr_out <= ns == SETUP || ns == LOAD;
      setup_serial_out <= (ns == SETUP || ns == LOAD) && sw_n[~cnt_n[2:0]];
      serial4_out <= ns == LOAD && a_n[~cnt_n[3:0]];
      serial3_out <= ns == LOAD && b_n[~cnt_n[3:0]];
      serial2_out <= ns == LOAD && c_n[~cnt_n[3:0]];
      serial1_out <= ns == LOAD && d_n[~cnt_n[3:0]];
      output_read_out <= ns == READ;
      result_valid <= ns == DONE;
    end
  end
`ifdef FP_ADDER_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign to_hit = state == WAIT_RDY && !dut_output_rdy_in && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tcnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt <= state == WAIT_RDY ? tcnt + TW'(1) : '0;
      timeout_err <= ns == DONE && (to_hit || timeout_err);
    end
  end
`else
  assign to_hit = 1'b0;
  assign timeout_err = TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_fp_adder_host.sv
// tb_fp_adder_host: directed self-checking bench for fp_adder_host
module tb_fp_adder_host;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, start_valid = 1'b0, result_ready = 1'b0;
  logic in_rdy = 1'b1, out_rdy = 1'b0, ser_in = 1'b0;
  logic [15:0] op_a = '0, op_b = '0, op_c = '0, op_d = '0;
  logic [2:0] sub_op = '0;
  logic [3:0] lane_en = '0;
  logic start_ready, result_valid, timeout_err;
  logic [15:0] result_out;
  logic s1, s2, s3, s4, ss, wr, rd, oclk;
  int tests = 0, fails = 0;
  fp_adder_host #(.WIDTH(16), .TIMEOUT(20)) dut (
    .clk_in(clk), .rst_in(rst), .start_valid_in(start_valid), .start_ready(start_ready),
    .op_a_in(op_a), .op_b_in(op_b), .op_c_in(op_c), .op_d_in(op_d),
    .sub_op_in(sub_op), .lane_en_in(lane_en), .result_valid(result_valid),
    .result_ready_in(result_ready), .result_out(result_out), .timeout_err(timeout_err),
    .dut_input_rdy_in(in_rdy), .dut_output_rdy_in(out_rdy), .dut_serial_in(ser_in),
    .serial1_out(s1), .serial2_out(s2), .serial3_out(s3), .serial4_out(s4),
    .setup_serial_out(ss), .wr_out(wr), .output_read_out(rd), .output_clk_out(oclk)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tests++;
    if (start_ready !== 1'b1) begin fails++; $display("FAIL reset_start_ready got %b exp 1", start_ready); end
    tests++;
    if ({wr, ss, s1, s2, s3, s4, rd, result_valid, oclk, timeout_err} !== 10'b0) begin
      fails++; $display("FAIL reset_outputs got %b exp 0", {wr, ss, s1, s2, s3, s4, rd, result_valid, oclk, timeout_err});
    end
    tests++;
    if (result_out !== 16'h0000) begin fails++; $display("FAIL reset_result got %h exp 0000", result_out); end
  endtask
  task automatic test_frame;
    logic [7:0] sp;
    logic [15:0] l4, l3, l2, l1, sl;
    int wrc;
    logic bad;
    op_a = 16'h3C00; op_b = 16'h1234; op_c = 16'hABCD; op_d = 16'h0F0F;
    sub_op = 3'b000; lane_en = 4'b1111; start_valid = 1'b1;
    tick;
    start_valid = 1'b0;
    wrc = 0; bad = 1'b0; sp = '0;
    for (int k = 0; k < 8; k++) begin
      sp = {sp[6:0], ss}; wrc += int'(wr);
      if ({s4, s3, s2, s1} !== 4'b0) bad = 1'b1;
      tick;
    end
    tests++;
    if (sp !== 8'h1E) begin fails++; $display("FAIL setup_pattern got %h exp 1e", sp); end
    tests++;
    if (bad !== 1'b0) begin fails++; $display("FAIL setup_lanes_quiet got %b exp 0", bad); end
    tests++;
    if (wr !== 1'b0) begin fails++; $display("FAIL gap_wr got %b exp 0", wr); end
    tick;
    l4 = '0; l3 = '0; l2 = '0; l1 = '0; sl = '0;
    for (int k = 0; k < 16; k++) begin
      l4 = {l4[14:0], s4}; l3 = {l3[14:0], s3}; l2 = {l2[14:0], s2}; l1 = {l1[14:0], s1};
      sl = {sl[14:0], ss}; wrc += int'(wr);
      tick;
    end
    tests++;
    if (l4 !== 16'h3C00) begin fails++; $display("FAIL lane4_stream got %h exp 3c00", l4); end
    tests++;
    if (l3 !== 16'h1234) begin fails++; $display("FAIL lane3_stream got %h exp 1234", l3); end
    tests++;
    if (l2 !== 16'hABCD) begin fails++; $display("FAIL lane2_stream got %h exp abcd", l2); end
    tests++;
    if (l1 !== 16'h0F0F) begin fails++; $display("FAIL lane1_stream got %h exp 0f0f", l1); end
    tests++;
    if (sl !== 16'h1E1E) begin fails++; $display("FAIL load_setup_repeat got %h exp 1e1e", sl); end
    for (int k = 0; k < 10; k++) begin
      wrc += int'(wr);
      tick;
    end
    tests++;
    if (wrc != 24) begin fails++; $display("FAIL wr_count got %0d exp 24", wrc); end
  endtask
  task automatic read_word(input logic [15:0] word, input string tag);
    int rdc;
    logic early;
    out_rdy = 1'b1;
    tick;
    out_rdy = 1'b0;
    rdc = 0; early = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rdc += int'(rd);
      if (result_valid) early = 1'b1;
      ser_in = word[15-k];
      tick;
    end
    ser_in = 1'b0;
    tests++;
    if (result_valid !== 1'b1) begin fails++; $display("FAIL %s_valid_timing got %b exp 1", tag, result_valid); end
    tests++;
    if (early !== 1'b0) begin fails++; $display("FAIL %s_valid_early got %b exp 0", tag, early); end
    tests++;
    if (result_out !== word) begin fails++; $display("FAIL %s_result got %h exp %h", tag, result_out, word); end
    tests++;
    if (rdc != 16 || rd !== 1'b0) begin fails++; $display("FAIL %s_read_len got %0d/%b exp 16/0", tag, rdc, rd); end
  endtask
  task automatic test_read;
    read_word(16'h4500, "read");
  endtask
  task automatic test_hold;
    logic unstable, taken;
    result_ready = 1'b0; start_valid = 1'b1; op_a = 16'hFFFF;
    unstable = 1'b0; taken = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (result_out !== 16'h4500 || result_valid !== 1'b1) unstable = 1'b1;
      if (start_ready !== 1'b0 || wr !== 1'b0) taken = 1'b1;
      tick;
    end
    tests++;
    if (unstable !== 1'b0) begin fails++; $display("FAIL hold_stable got %b exp 0", unstable); end
    tests++;
    if (taken !== 1'b0) begin fails++; $display("FAIL hold_no_accept got %b exp 0", taken); end
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    tests++;
    if ({result_valid, wr, start_ready} !== 3'b001) begin
      fails++; $display("FAIL simul_idle got %b exp 001", {result_valid, wr, start_ready});
    end
    tick;
    start_valid = 1'b0;
    tests++;
    if (wr !== 1'b1) begin fails++; $display("FAIL simul_next_accept got %b exp 1", wr); end
  endtask
  task automatic test_reset_mid_load;
    for (int k = 0; k < 14; k++) tick;
    tests++;
    if ({wr, s4} !== 2'b11) begin fails++; $display("FAIL mid_load_active got %b exp 11", {wr, s4}); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests++;
    if ({wr, ss, s1, s2, s3, s4, rd, result_valid} !== 8'b0 || start_ready !== 1'b1) begin
      fails++; $display("FAIL mid_load_reset got %b/%b exp 0/1", {wr, ss, s1, s2, s3, s4, rd, result_valid}, start_ready);
    end
  endtask
  task automatic test_input_rdy;
    logic bad;
    logic [7:0] sp;
    int n;
    in_rdy = 1'b0; start_valid = 1'b1;
    sub_op = 3'b101; lane_en = 4'b0010;
    op_a = 16'h0000; op_b = 16'h8001; op_c = 16'h0000; op_d = 16'h0000;
    #1;
    tests++;
    if (start_ready !== 1'b0) begin fails++; $display("FAIL inrdy_low_ready got %b exp 0", start_ready); end
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (wr !== 1'b0) bad = 1'b1;
      tick;
    end
    tests++;
    if (bad !== 1'b0) begin fails++; $display("FAIL inrdy_low_wr got %b exp 0", bad); end
    in_rdy = 1'b1;
    #1;
    tests++;
    if (start_ready !== 1'b1) begin fails++; $display("FAIL inrdy_high_ready got %b exp 1", start_ready); end
    tick;
    start_valid = 1'b0;
    sp = '0;
    for (int k = 0; k < 8; k++) begin
      sp = {sp[6:0], ss};
      tick;
    end
    tests++;
    if (sp !== 8'hA4) begin fails++; $display("FAIL setup_pattern2 got %h exp a4", sp); end
    for (int k = 0; k < 17; k++) tick;
`ifdef FP_ADDER_HOST_TIMEOUT_EN
    n = 0;
    while (!result_valid && n < 100) begin
      tick;
      n++;
    end
    tests++;
    if (n != 20) begin fails++; $display("FAIL timeout_cycles got %0d exp 20", n); end
    tests++;
    if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_err got %b exp 1", timeout_err); end
    tests++;
    if (result_out !== 16'h0000) begin fails++; $display("FAIL timeout_result got %h exp 0000", result_out); end
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    tests++;
    if ({timeout_err, result_valid} !== 2'b00) begin fails++; $display("FAIL timeout_clear got %b exp 00", {timeout_err, result_valid}); end
`else
    n = 0;
    for (int k = 0; k < 50; k++) begin
      if (result_valid || timeout_err || wr) n++;
      tick;
    end
    tests++;
    if (n != 0) begin fails++; $display("FAIL wait_forever got %0d exp 0", n); end
    read_word(16'hC0DE, "read2");
    tests++;
    if (timeout_err !== 1'b0) begin fails++; $display("FAIL no_timeout_err got %b exp 0", timeout_err); end
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
`endif
  endtask
  initial begin
    test_reset;
    test_frame;
    test_read;
    test_hold;
    test_reset_mid_load;
    test_input_rdy;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
